// File: rtl/hs_req_source.sv
// hs_req_source: four-phase req/ack source driving an incrementing word into another clock domain.
// Define HS_REQ_TIMEOUT_EN to abort stalled handshake phases after TIMEOUT cycles and raise timeout_err.
module hs_req_source #(
    parameter int DATA_W      = 4,
    parameter int WRAP_VAL    = 7,
    parameter int GAP         = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk_a,
    input  logic              rst,
    input  logic              en,
    input  logic              clr_err,
    input  logic              data_ack,
    output logic [DATA_W-1:0] data,
    output logic              data_req,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       xfer_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [15:0]            r_gap;
    logic                   w_ack_s;
    logic                   w_to;

    assign w_ack_s = r_sync[SYNC_STAGES-1];

`ifdef HS_REQ_TIMEOUT_EN
    logic [15:0] r_wait;
    logic        w_stall;
    // stalled means sitting in a handshake phase whose exit condition is not met this cycle
    assign w_stall = (r_state == REQ) ? !w_ack_s : (r_state == RELEASE) ? w_ack_s : 1'b0;
    assign w_to    = w_stall && (r_wait == 16'(TIMEOUT - 1));
`else
    logic w_unused;
    assign w_to     = 1'b0;
    assign w_unused = clr_err;
`endif

    always_ff @(posedge clk_a) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sync      <= '0;
            r_gap       <= '0;
            data        <= '0;
            data_req    <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            xfer_cnt    <= '0;
`ifdef HS_REQ_TIMEOUT_EN
            r_wait      <= '0;
`endif
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], data_ack};
`ifdef HS_REQ_TIMEOUT_EN
            r_wait      <= (w_stall && !w_to) ? r_wait + 16'd1 : '0;
            timeout_err <= w_to ? 1'b1 : clr_err ? 1'b0 : timeout_err;
`endif
            case (r_state)
                IDLE: begin
                    if (!en) begin
                        r_gap <= '0;
                    end else if (r_gap == 16'(GAP - 1)) begin
                        r_gap    <= '0;
                        r_state  <= REQ;
                        data_req <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        r_gap <= r_gap + 16'd1;
                    end
                end
                REQ: begin
                    if (w_ack_s) begin
                        r_state  <= RELEASE;
                        data_req <= 1'b0;
                    end else if (w_to) begin
                        r_state  <= IDLE;
                        data_req <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (!w_ack_s) begin
                        r_state  <= IDLE;
                        busy     <= 1'b0;
                        data     <= (data == DATA_W'(WRAP_VAL)) ? '0 : data + DATA_W'(1);
                        xfer_cnt <= xfer_cnt + 16'd1;
                    end else if (w_to) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hs_req_source.sv
// tb_hs_req_source: directed stimulus with an abstract handshake model checked every cycle.
// Timeout expectations follow HS_REQ_TIMEOUT_EN.
module tb_hs_req_source;
    localparam int DW = 4, WRAP = 7, GAP = 4, SS = 2, TO = 8, RX_DLY = 3;

    logic clk_a = 0, rst = 1, en = 0, clr_err = 0;
    logic data_ack;
    logic [DW-1:0] data;
    logic data_req, busy, timeout_err;
    logic [15:0] xfer_cnt;

    int n_tests = 0, n_fail = 0;
    bit rx_on = 0, ack_man = 0, rx_ack = 0, chk_on = 0;
    int rx_cnt = 0;

    hs_req_source #(.DATA_W(DW), .WRAP_VAL(WRAP), .GAP(GAP), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk_a(clk_a), .rst(rst), .en(en), .clr_err(clr_err), .data_ack(data_ack),
        .data(data), .data_req(data_req), .busy(busy), .timeout_err(timeout_err), .xfer_cnt(xfer_cnt)
    );

    always #5 clk_a = ~clk_a;

    assign data_ack = rx_on ? rx_ack : ack_man;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Receiver follows data_req with RX_DLY cycles of latency in both directions
    always @(negedge clk_a) begin
        if (!rx_on) begin
            rx_ack = 0;
            rx_cnt = 0;
        end else if (data_req != rx_ack) begin
            if (rx_cnt == RX_DLY - 1) begin
                rx_ack = data_req;
                rx_cnt = 0;
            end else rx_cnt++;
        end else rx_cnt = 0;
    end

    // Abstract model: phase number, delayed ack samples, and completed-transfer count
    int m_phase = 0, m_gap = 0, m_wait = 0, m_done = 0;
    bit m_err = 0;
    bit ack_h[$];
    always @(posedge clk_a) begin
        bit s, fire;
        fire = 0;
        if (rst) begin
            m_phase = 0; m_gap = 0; m_wait = 0; m_done = 0; m_err = 0;
            ack_h.delete();
            for (int i = 0; i < SS; i++) ack_h.push_back(1'b0);
        end else begin
            s = ack_h.pop_front();
            ack_h.push_back(data_ack);
            if (m_phase == 0) begin
                if (!en) m_gap = 0;
                else if (m_gap == GAP - 1) begin m_gap = 0; m_phase = 1; m_wait = 0; end
                else m_gap++;
            end else if (m_phase == 1 ? s : !s) begin
                if (m_phase == 2) m_done++;
                m_phase = (m_phase + 1) % 3;
                m_wait = 0;
            end else begin
`ifdef HS_REQ_TIMEOUT_EN
                if (m_wait == TO - 1) begin m_phase = 0; fire = 1; end
`endif
                m_wait++;
            end
`ifdef HS_REQ_TIMEOUT_EN
            if (fire) m_err = 1;
            else if (clr_err) m_err = 0;
`endif
        end
    end

    logic p_busy = 0, p_req = 0;
    logic [DW-1:0] p_data = 0;
    int offered[$];
    always @(negedge clk_a) begin
        if (chk_on) begin
            chk("data", data, m_done % (WRAP + 1));
            chk("data_req", data_req, int'(m_phase == 1));
            chk("busy", busy, int'(m_phase != 0));
            chk("timeout_err", timeout_err, int'(m_err));
            chk("xfer_cnt", xfer_cnt, m_done % 65536);
            if (p_busy && busy) chk("data_hold", data, p_data);
            if (data_req && !p_req) offered.push_back(int'(data));
        end
        p_busy = busy; p_req = data_req; p_data = data;
    end

    task automatic do_reset();
        en = 0; rx_on = 0; ack_man = 0; clr_err = 0;
        @(negedge clk_a) rst = 1;
        @(negedge clk_a);
        chk("rst_data", data, 0);
        chk("rst_req", data_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_xfer", xfer_cnt, 0);
        chk_on = 1;
        rst = 0;
    endtask

    int exp_w[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    int seen;

    initial begin
        // Timing: req after edge GAP, ack at edge 10 drops req after edge 12
        do_reset();
        en = 1;
        repeat (3) @(negedge clk_a);
        chk("A_req_e3", data_req, 0);
        @(negedge clk_a);
        chk("A_req_e4", data_req, 1);
        repeat (5) @(negedge clk_a);
        ack_man = 1;
        repeat (2) @(negedge clk_a);
        chk("A_req_e11", data_req, 1);
        @(negedge clk_a);
        chk("A_req_e12", data_req, 0);
        chk("A_busy_e12", busy, 1);
        ack_man = 0;
        repeat (2) @(negedge clk_a);
        chk("A_data_e14", data, 0);
        @(negedge clk_a);
        chk("A_data_e15", data, 1);
        chk("A_xfer_e15", xfer_cnt, 1);
        chk("A_busy_e15", busy, 0);

        // Nine transfers wrap the word through 0..7,0
        do_reset();
        offered.delete();
        en = 1; rx_on = 1;
        for (int i = 0; i < 600 && xfer_cnt != 9; i++) @(negedge clk_a);
        chk("B_xfer", xfer_cnt, 9);
        chk("B_data", data, 1);
        chk("B_offered_n", offered.size(), 9);
        for (int i = 0; i < 9 && i < offered.size(); i++) chk("B_word", offered[i], exp_w[i]);

        // Dropping en mid-REQ still completes the transfer
        do_reset();
        en = 1; rx_on = 1;
        for (int i = 0; i < 20 && !data_req; i++) @(negedge clk_a);
        chk("C_req_up", data_req, 1);
        en = 0;
        for (int i = 0; i < 60 && xfer_cnt != 1; i++) @(negedge clk_a);
        chk("C_xfer", xfer_cnt, 1);
        chk("C_data", data, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk_a);
            if (data_req) seen++;
        end
        chk("C_no_req", seen, 0);
        en = 1;
        repeat (3) @(negedge clk_a);
        chk("C_req_g3", data_req, 0);
        @(negedge clk_a);
        chk("C_req_g4", data_req, 1);

        // Stalled receiver; clr_err coincides with the timeout edge
        do_reset();
        en = 1;
        repeat (11) @(negedge clk_a);
        chk("D_req_e11", data_req, 1);
        clr_err = 1;
        @(negedge clk_a);
`ifdef HS_REQ_TIMEOUT_EN
        chk("D_req_e12", data_req, 0);
        chk("D_err_e12", timeout_err, 1);
        chk("D_data_e12", data, 0);
        chk("D_xfer_e12", xfer_cnt, 0);
`else
        chk("D_req_e12", data_req, 1);
        chk("D_err_e12", timeout_err, 0);
`endif
        @(negedge clk_a);
        chk("D_err_e13", timeout_err, 0);
        clr_err = 0;
        repeat (3) @(negedge clk_a);
`ifdef HS_REQ_TIMEOUT_EN
        chk("D_reoffer_req", data_req, 1);
        chk("D_reoffer_data", data, 0);
`else
        chk("D_req_held", data_req, 1);
`endif

        // Reset during RELEASE
        do_reset();
        en = 1; rx_on = 1;
        for (int i = 0; i < 400 && xfer_cnt != 5; i++) @(negedge clk_a);
        for (int i = 0; i < 40 && !(busy && !data_req); i++) @(negedge clk_a);
        chk("E_in_release", int'(busy && !data_req), 1);
        chk("E_data5", data, 5);
        rst = 1; en = 0;
        @(negedge clk_a);
        chk("E_data", data, 0);
        chk("E_req", data_req, 0);
        chk("E_busy", busy, 0);
        chk("E_xfer", xfer_cnt, 0);
        rst = 0;
        repeat (5) @(negedge clk_a);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hs_req_source.md
# hs_req_source

Parametrised single-clock request/acknowledge data source: next generation of the team's handshake driver. Drives a DATA_W-bit incrementing data word with a full four-phase req/ack protocol toward a receiver in another clock domain. Synchronises the returning ack internally, holds data stable for the whole transfer, counts completed transfers and optionally flags a stalled receiver.

## Interface
- DATA_W, 4: data word width (>=1)
- WRAP_VAL, 7: last data value before wrap to 0 (< 2^DATA_W)
- GAP, 4: idle cycles between transfers (>=1)
- SYNC_STAGES, 2: ack synchroniser depth (>=2)
- TIMEOUT, 255: wait-cycle limit per handshake phase (>=1, fits 16 bits)
- clk_a  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  permit new transfers
- clr_err  input  1  clears timeout_err
- data_ack  input  1  ack from receiver domain, asynchronous to clk_a
- data  output  DATA_W  transfer word
- data_req  output  1  request, registered
- busy  output  1  high in REQ or RELEASE
- timeout_err  output  1  sticky stall flag
- xfer_cnt  output  16  completed transfers, wraps 0xFFFF->0

## Operation
- Reset (rst high at an edge): state IDLE, data=0, data_req=0, busy=0, timeout_err=0, xfer_cnt=0, gap and wait counters 0, synchroniser flops 0.
- data_ack passes through SYNC_STAGES flops -> ack_s; FSM uses only ack_s.
- IDLE: en=1 -> gap_cnt+1 each cycle; en=0 -> gap_cnt cleared. gap_cnt==GAP-1 with en=1 -> REQ, gap_cnt cleared.
- REQ: data_req=1. ack_s=1 -> RELEASE.
- RELEASE: data_req=0. ack_s=0 -> IDLE; same edge: data <= (data==WRAP_VAL) ? 0 : data+1; xfer_cnt+1.
- data changes only on RELEASE->IDLE; constant whenever data_req=1 or busy=1.
- en only gates starting a transfer; deasserting en in REQ/RELEASE does not abort.
- ack_s already 1 on IDLE->REQ: REQ lasts one cycle, then RELEASE waits for ack_s=0.
- Timeout (macro enabled): wait_cnt clears on entering REQ/RELEASE, +1 per cycle there. wait_cnt==TIMEOUT-1 without exit condition -> IDLE, data_req=0, timeout_err=1; data and xfer_cnt unchanged (same word re-offered next transfer).
- clr_err=1 clears timeout_err; timeout and clr_err same cycle -> timeout_err=1 (set wins).
- rst mid-handshake: everything back to reset values next edge; receiver must tolerate req dropping.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- en high from first edge after reset release (edge 1): data_req rises after edge GAP.
- data_ack first sampled high at edge k: data_req falls after edge k+SYNC_STAGES.
- data_ack first sampled low at edge m (in RELEASE): data/xfer_cnt update after edge m+SYNC_STAGES; next data_req rise GAP edges later if en=1.
- Minimum transfer period: GAP + 2*SYNC_STAGES + 2 cycles plus receiver latency.
- busy follows state: high from the edge data_req rises to the edge RELEASE exits.

## Configuration
- HS_REQ_TIMEOUT_EN defined: wait counter and timeout behaviour as above.
- Undefined: no wait counter; FSM waits indefinitely in REQ/RELEASE; timeout_err held 0, clr_err ignored; port list unchanged.

## Test plan
- Defaults, en=1, receiver acks 3 cycles after req rise and drops ack 3 cycles after req fall -> data 0,1,...,7,0 over 9 transfers; xfer_cnt=9; data never changes while data_req=1.
- GAP=4, SYNC_STAGES=2: rst released before edge 1, en=1 -> data_req high after edge 4; ack sampled high edge 10 -> data_req low after edge 12.
- en dropped while in REQ -> transfer completes, data 0->1, xfer_cnt=1; no further data_req while en=0; en re-raised -> data_req after GAP edges.
- HS_REQ_TIMEOUT_EN, TIMEOUT=8, ack never asserted -> data_req low and timeout_err=1 8 cycles after entering REQ; data=0, xfer_cnt=0; next req re-offers data=0.
- Timeout and clr_err same cycle -> timeout_err=1; clr_err next cycle -> 0. Macro undefined, same stimulus -> data_req stays high, timeout_err=0.
- rst pulsed during RELEASE with data=5 -> next edge data=0, data_req=0, busy=0, xfer_cnt=0, state IDLE.
